// File: rtl/dbuf_pkg.sv
// Shared types and helpers for the ping-pong double-buffer controller.
// Declarations only: no latency and no flow control of its own.
package dbuf_pkg;
    localparam int RD_LAT_LOW  = 1;
    localparam int RD_LAT_HIGH = 2;

    typedef logic bank_t;

    typedef struct packed {
        logic  valid;
        bank_t bank;
        logic  last;
    } rd_tag_t;

    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) res = i + 1;
        end
        return res;
    endfunction
endpackage

// File: rtl/dbuf_skid_fifo.sv
// First-word-fall-through register FIFO with occupancy count.
// Latency: a push is visible at the output next cycle; the head holds until out_rdy_i pops it.
module dbuf_skid_fifo
    import dbuf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clka,
    input  logic             rstb,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_dat_o,
    input  logic             out_rdy_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = in_vld_i;
    assign out_vld_o = (cnt_q != '0);
    assign pop       = out_vld_o & out_rdy_i;
    assign out_dat_o = mem_q[rptr_q];
    assign cnt_o     = cnt_q;

    always_ff @(posedge clka) begin
        if (push) mem_q[wptr_q] <= in_dat_i;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The issue throttle upstream keeps outstanding reads within DEPTH.
    always_ff @(posedge clka) begin
        if (!rstb) assert (!(push && !pop && (cnt_q == CNT_W'(DEPTH))));
    end
endmodule

// File: rtl/dbuf_pingpong_ctrl.sv
// Ping-pong controller: producer fills one external BRAM bank while the consumer drains the other.
// Latency: first rd_valid RD_LAT+1 cycles after a bank fills; rd_ready back-pressure throttles read issue via the skid FIFO.
module dbuf_pingpong_ctrl
    import dbuf_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 512,
    parameter int ADDR_W    = clogb2(RAM_DEPTH - 1),
    parameter int BLOCK_LEN = 512,
    parameter int RD_LAT    = RD_LAT_LOW
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [1:0]        bank_full,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [1:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [1:0]        ram_enb,
    input  logic [DATA_W-1:0] ram_doutb0,
    input  logic [DATA_W-1:0] ram_doutb1
);
    localparam int                FIFO_DEPTH = RD_LAT + 1;
    localparam int                FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BLOCK_LEN - 1);

    bank_t             wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [1:0]        bank_full_q, bank_full_d;
    rd_tag_t           tag_q [RD_LAT];
    rd_tag_t           tag_d [RD_LAT];
    rd_tag_t           tag_exit;

    logic                  wr_fire, wr_at_end, rd_issue, rd_at_end, rd_pop;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    int                    occ;

    assign wr_ready  = !bank_full_q[wbank_q];
    assign wr_fire   = wr_valid & wr_ready;
    assign wr_at_end = (wcnt_q == LAST_ADDR);
    assign rd_at_end = (rcnt_q == LAST_ADDR);
    assign rd_pop    = rd_valid & rd_ready;
    assign bank_full = bank_full_q;

    assign ram_addra = wcnt_q;
    assign ram_dina  = wr_data;
    assign ram_wea   = wr_fire ? (2'b01 << wbank_q) : 2'b00;
    assign ram_addrb = rcnt_q;
    assign ram_enb   = rd_issue ? (2'b01 << rbank_q) : 2'b00;

    // Occupancy counts FIFO words plus reads still in the BRAM pipe, net of this cycle's pop.
    always_comb begin
        occ = int'(fifo_cnt) - int'(rd_pop);
        for (int i = 0; i < RD_LAT; i++) occ += int'(tag_q[i].valid);
        rd_issue = bank_full_q[rbank_q] && (occ < RD_LAT + 1);
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        bank_full_d = bank_full_q;
        if (wr_fire) begin
            if (wr_at_end) begin
                wcnt_d               = '0;
                wbank_d              = ~wbank_q;
                bank_full_d[wbank_q] = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        // Writer and reader always own different banks, so both updates can land together.
        if (rd_issue) begin
            if (rd_at_end) begin
                rcnt_d               = '0;
                rbank_d              = ~rbank_q;
                bank_full_d[rbank_q] = 1'b0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        tag_d[0].valid = rd_issue;
        tag_d[0].bank  = rbank_q;
        tag_d[0].last  = rd_at_end;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wbank_q     <= '0;
            rbank_q     <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            bank_full_q <= '0;
            tag_q       <= '{default: '0};
        end else begin
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            bank_full_q <= bank_full_d;
            tag_q       <= tag_d;
        end
    end

    assign tag_exit = tag_q[RD_LAT-1];

    dbuf_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_skid (
        .clka      (clka),
        .rstb      (rstb),
        .in_vld_i  (tag_exit.valid),
        .in_dat_i  ({tag_exit.last, (tag_exit.bank ? ram_doutb1 : ram_doutb0)}),
        .out_vld_o (rd_valid),
        .out_dat_o ({rd_last, rd_data}),
        .out_rdy_i (rd_ready),
        .cnt_o     (fifo_cnt)
    );
endmodule

// File: doc/dbuf_pingpong_ctrl.md
Name: dbuf_pingpong_ctrl

Overview:
Ping-pong (double-buffer) controller for two 32x512 simple-dual-port single-clock BRAM banks in the buffer-control path. A producer stream fills one bank with a fixed-length block while a consumer stream drains the other bank. Banks swap automatically at block boundaries. Variable BRAM read latency and consumer back-pressure are absorbed by a small skid FIFO.

Parameters:
DATA_W, 32, word width of stream and BRAM data.
RAM_DEPTH, 512, entries per bank.
ADDR_W, 9, BRAM address width, equal to clogb2(RAM_DEPTH-1).
BLOCK_LEN, 512, words per block, range 2..RAM_DEPTH.
RD_LAT, 1, BRAM read latency in cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE.

Ports:
clka  in  1  clock
rstb  in  1  reset, synchronous, active-high
wr_valid  in  1  producer word valid
wr_data  in  DATA_W  producer word
wr_ready  out  1  producer may transfer
rd_valid  out  1  consumer word valid
rd_data  out  DATA_W  consumer word
rd_ready  in  1  consumer accepts word
rd_last  out  1  rd_data is the last word of a block
bank_full  out  2  per-bank full flag, bit i = bank i
ram_addra  out  ADDR_W  shared write address to both banks
ram_dina  out  DATA_W  shared write data
ram_wea  out  2  per-bank write enable
ram_addrb  out  ADDR_W  shared read address
ram_enb  out  2  per-bank read enable
ram_doutb0  in  DATA_W  bank 0 read data
ram_doutb1  in  DATA_W  bank 1 read data

Behaviour:
- Reset (rstb=1 at an edge):
  - wbank=rbank=0, wcnt=rcnt=0, bank_full=00.
  - Skid FIFO empty; in-flight pipeline cleared.
  - Outputs: wr_ready=1 after reset, rd_valid=0, rd_last=0, ram_wea=00, ram_enb=00, addresses 0.
  - Reset mid-operation drops all partial blocks and in-flight reads. BRAM contents are not cleared; both banks are treated as empty.
- Write side:
  - wr_ready = !bank_full[wbank], combinational from registers.
  - On a transfer (wr_valid & wr_ready): ram_wea[wbank]=1, ram_addra=wcnt, ram_dina=wr_data, all in the same cycle. wcnt increments.
  - When wcnt==BLOCK_LEN-1 on a transfer: wcnt<=0, bank_full[wbank]<=1, wbank toggles.
  - Back-to-back writes continue into the other bank with no bubble if that bank is empty.
- Read issue:
  - issue = bank_full[rbank] & (fifo_cnt + inflight - pop < RD_LAT+1), where pop = rd_valid & rd_ready.
  - On issue: ram_enb[rbank]=1, ram_addrb=rcnt. ram_enb=00 whenever not issuing.
  - When rcnt==BLOCK_LEN-1 on an issue: rcnt<=0, bank_full[rbank]<=0, rbank toggles. The bank is released at the same edge as the last read issue; the writer can write it from the next cycle.
- Simultaneous bank_full set (writer) and clear (reader) always target different banks and both take effect at the same edge.
- In-flight tracking:
  - A shift pipeline RD_LAT deep carries {valid, bank, last} per issued read.
  - At pipeline exit, the word is taken from ram_doutb0 or ram_doutb1 according to the carried bank and pushed into the skid FIFO with its last flag.
- Skid FIFO:
  - Depth RD_LAT+1, first-word-fall-through.
  - rd_valid = not empty; rd_data and rd_last come from the head entry.
  - Push and pop in the same cycle are allowed.
  - The FIFO never overflows by construction; overflow is an assertion failure.
- Throughput: 1 word/cycle each side in steady state. First rd_valid appears RD_LAT+1 cycles after the bank_full bit rises.
- Ordering: words are output in write order, with no loss or duplication under any rd_ready pattern.

Decomposition:
- Shared package dbuf_pkg:
  - clogb2 function.
  - Read-latency constants RD_LAT_LOW=1, RD_LAT_HIGH=2.
  - Bank index type (1 bit).
  - In-flight tag struct {valid, bank, last}.
- One sub-module: dbuf_skid_fifo (parameters WIDTH, DEPTH). It is a register FIFO with count output, first-word-fall-through, and synchronous active-high reset.
- Top-level integration instantiates the two BRAM banks and ties the BRAM rstb to the same rstb.

Test Plan:
- Post-reset check: wr_ready=1, rd_valid=0, bank_full=00, ram_wea=00, ram_enb=00 on the first cycle after rstb deasserts.
- Write 0..1023 back-to-back with rd_ready=1 (RD_LAT=1):
  - bank_full[0] rises the cycle after the 512th accept.
  - Writes continue into bank 1 with no wr_ready drop.
  - rd_data is 0..1023, with rd_last on words 511 and 1023, and first rd_valid 2 cycles after bank_full[0] rises.
- Hold rd_ready=0 and write 1024 words:
  - bank_full=11, wr_ready=0.
  - Exactly RD_LAT+1 ram_enb pulses occur, then ram_enb stays 00.
  - On releasing rd_ready, all 1024 words arrive in order.
- RD_LAT=2 with random rd_ready (50%) over 4 blocks: scoreboard shows order preserved, no loss or duplication, and no FIFO overflow assertion.
- BLOCK_LEN=4: write bank 1's last word in the same cycle as bank 0's last read issue. bank_full goes 01 -> 10 at one edge, and wcnt and rcnt both wrap to 0.
- Assert rstb after 100 writes into bank 1 while bank 0 is draining:
  - The next cycle shows reset outputs and rd_valid=0.
  - A following write lands at bank 0, address 0.
  - No stale word is ever output.
